// File: rtl/jtag_host.sv
// jtag_host: clk-domain JTAG initiator. Walks the TAP from Run-Test/Idle
// through a single IR or DR scan (or a TRST + TMS reset sequence), drives
// TCK/TMS/TDI/TRST_N, samples TDO, and returns the captured bits as a
// one-cycle response. The TAP is always parked in Run-Test/Idle between
// commands.
module jtag_host #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [5:0]         cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               tck,
   output logic               tms,
   output logic               tdi,
   output logic               trst_n,
   input  logic               tdo
);

   localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [5:0]        LEN_MAX    = 6'(MAX_LEN);
   localparam logic [5:0]        LEN_MAX_M1 = 6'(MAX_LEN - 1);
   localparam logic [5:0]        RST_LAST   = 6'd6;

   typedef enum logic [2:0] {
      RST_SEQ,
      IDLE,
      PRE,
      SHIFT,
      POST,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [5:0]           bit_q, bit_d;
   logic [DIV_W-1:0]     div_q;
   logic                 high_q;
   logic                 tms_d, tdi_d, trst_d;
   logic                 is_ir_q, from_cmd_q;
   logic [5:0]           len_m1_q;
   logic [MAX_LEN-1:0]   data_q;
   logic [MAX_LEN-1:0]   mask_q;
   logic                 running;
   logic                 phase_end, rise, bit_end;
   logic                 accept, sample, shift_adv;

   // Effective scan length minus one: 0 behaves as 1, anything above
   // MAX_LEN behaves as MAX_LEN.
   function automatic logic [5:0] eff_len_m1(input logic [5:0] len);
      if (len == 6'd0)
         return 6'd0;
      else if (len > LEN_MAX)
         return LEN_MAX_M1;
      else
         return len - 6'd1;
   endfunction

   assign running   = (state_q == RST_SEQ) || (state_q == PRE) ||
                      (state_q == SHIFT)   || (state_q == POST);
   assign phase_end = (div_q == DIV_LAST);
   assign rise      = phase_end && !high_q;
   assign bit_end   = phase_end && high_q;
   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == DONE);

   // State, bit index and JTAG pin registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_SEQ;
         bit_q   <= '0;
         tms     <= 1'b1;
         tdi     <= 1'b0;
         trst_n  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         tms     <= tms_d;
         tdi     <= tdi_d;
         trst_n  <= trst_d;
      end
   end

   // Next state, next bit index and the TMS/TDI/TRST values for the next
   // bit period; pins only change at the start of a low phase.
   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      tms_d     = tms;
      tdi_d     = tdi;
      trst_d    = trst_n;
      accept    = 1'b0;
      sample    = 1'b0;
      shift_adv = 1'b0;
      case (state_q)
         IDLE: begin
            tms_d = 1'b0;
            tdi_d = 1'b0;
            if (cmd_valid) begin
               accept = 1'b1;
               bit_d  = '0;
               tms_d  = 1'b1;
               if (cmd_op[1]) begin
                  state_d = RST_SEQ;
                  trst_d  = 1'b0;
               end else begin
                  state_d = PRE;
               end
            end
         end
         RST_SEQ: begin
            if (bit_end) begin
               trst_d = 1'b1;
               if (bit_q == RST_LAST) begin
                  state_d = from_cmd_q ? DONE : IDLE;
                  bit_d   = '0;
                  tms_d   = 1'b0;
               end else begin
                  bit_d = bit_q + 6'd1;
                  tms_d = (bit_q != RST_LAST - 6'd1);
               end
            end
         end
         PRE: begin
            if (bit_end) begin
               if (bit_q == (is_ir_q ? 6'd3 : 6'd2)) begin
                  state_d = SHIFT;
                  bit_d   = '0;
                  tms_d   = (len_m1_q == 6'd0);
                  tdi_d   = data_q[0];
               end else begin
                  bit_d = bit_q + 6'd1;
                  tms_d = is_ir_q && (bit_q == 6'd0);
               end
            end
         end
         SHIFT: begin
            sample = rise;
            if (bit_end) begin
               if (bit_q == len_m1_q) begin
                  state_d = POST;
                  bit_d   = '0;
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end else begin
                  shift_adv = 1'b1;
                  bit_d     = bit_q + 6'd1;
                  tms_d     = ((bit_q + 6'd1) == len_m1_q);
                  tdi_d     = data_q[1];
               end
            end
         end
         POST: begin
            if (bit_end) begin
               tms_d = 1'b0;
               if (bit_q == 6'd1) begin
                  state_d = DONE;
                  bit_d   = '0;
               end else begin
                  bit_d = 6'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = RST_SEQ;
         end
      endcase
   end

   // TCK generator: CLK_DIV low cycles then CLK_DIV high cycles per bit;
   // the first reset-sequence bit holds TCK low while TRST is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q  <= '0;
         high_q <= 1'b0;
         tck    <= 1'b0;
      end else if (running) begin
         if (phase_end) begin
            div_q  <= '0;
            high_q <= !high_q;
            tck    <= !high_q && !((state_q == RST_SEQ) && (bit_q == 6'd0));
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end else begin
         div_q  <= '0;
         high_q <= 1'b0;
         tck    <= 1'b0;
      end
   end

   // Command capture, TDI source shifting and TDO capture into rsp_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_ir_q    <= 1'b0;
         from_cmd_q <= 1'b0;
         len_m1_q   <= '0;
         data_q     <= '0;
         mask_q     <= '0;
         rsp_data   <= '0;
      end else begin
         if (accept) begin
            is_ir_q    <= cmd_op[0];
            from_cmd_q <= cmd_op[1];
            len_m1_q   <= eff_len_m1(cmd_len);
            data_q     <= cmd_data;
            mask_q     <= MAX_LEN'(1);
            rsp_data   <= '0;
         end else begin
            if (sample && tdo)
               rsp_data <= rsp_data | mask_q;
            if (shift_adv) begin
               data_q <= data_q >> 1;
               mask_q <= mask_q << 1;
            end
         end
      end
   end

endmodule
